// File: rtl/regfile_frame_stack.sv
// Dual-port register file with memory-mapped IO registers and an internal frame stack
// that saves/restores registers 0..NFRAME-1 one per cycle. Optional macro: REGFILE_WRITE_BYPASS_EN.
module regfile_frame_stack #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 6,
    parameter int NFRAME      = 15,
    parameter int STACK_DEPTH = 8,
    parameter int IO_IN_IDX   = 15,
    parameter int IO_OUT_IDX  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [DATA_W-1:0] w1,
    input  logic [DATA_W-1:0] w2,
    input  logic              w1_en,
    input  logic              w2_en,
    input  logic              r1_en,
    input  logic              r2_en,
    input  logic [DATA_W-1:0] io_in,
    input  logic              save_req,
    input  logic              restore_req,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] io_out,
    output logic              busy,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int CNT_W  = (NFRAME > 1) ? $clog2(NFRAME) : 1;
    localparam int SP_W   = $clog2(STACK_DEPTH + 1);
    localparam int SLOT_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NFRAME - 1);
    localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] IO_IN_A  = ADDR_W'(IO_IN_IDX);
    localparam logic [ADDR_W-1:0] IO_OUT_A = ADDR_W'(IO_OUT_IDX);

    // A restore must never race the io_in overwrite of its own register.
    if (NFRAME > IO_IN_IDX) begin : g_bad_nframe
        $error("regfile_frame_stack: NFRAME must not exceed IO_IN_IDX");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, SAVE = 2'd1, RESTORE = 2'd2} state_t;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [DATA_W-1:0]            stack_q [STACK_DEPTH][NFRAME];
    logic [DATA_W-1:0]            r1_q, r2_q, io_out_q;
    logic [DATA_W-1:0]            rd1_d, rd2_d;
    logic [SP_W-1:0]              sp_q;
    logic [CNT_W-1:0]             cnt_q;
    logic                         err_q;
    state_t                       state_q;
    logic [SLOT_W-1:0]            slot_s;
    logic [ADDR_W-1:0]            cnt_addr_s;

    assign slot_s     = sp_q[SLOT_W-1:0];
    assign cnt_addr_s = ADDR_W'(cnt_q);

    // Read data presented to the port registers at the next edge.
    always_comb begin
        rd1_d = regs_q[a1];
        rd2_d = regs_q[a2];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (a1 == IO_IN_A) begin
            rd1_d = io_in;
        end else if (w2_en && (a2 == a1)) begin
            rd1_d = w2;
        end else if (w1_en) begin
            rd1_d = w1;
        end else begin
            rd1_d = regs_q[a1];
        end
        if (a2 == IO_IN_A) begin
            rd2_d = io_in;
        end else if (w2_en) begin
            rd2_d = w2;
        end else if (w1_en && (a1 == a2)) begin
            rd2_d = w1;
        end else begin
            rd2_d = regs_q[a2];
        end
`endif
    end

    // Register file, port reads, IO mirroring and the save/restore sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q   <= '0;
            r1_q     <= {DATA_W{1'b0}};
            r2_q     <= {DATA_W{1'b0}};
            io_out_q <= {DATA_W{1'b0}};
            sp_q     <= {SP_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            err_q    <= 1'b0;
            state_q  <= IDLE;
        end else begin
            io_out_q <= regs_q[IO_OUT_A];
            case (state_q)
                IDLE: begin
                    if (r1_en) r1_q <= rd1_d;
                    if (r2_en) r2_q <= rd2_d;
                    if (w1_en) regs_q[a1] <= w1;
                    if (w2_en) regs_q[a2] <= w2;
                    if (save_req && restore_req) begin
                        err_q <= 1'b1;
                    end else if (save_req) begin
                        if (sp_q == SP_FULL) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= SAVE;
                            cnt_q   <= {CNT_W{1'b0}};
                        end
                    end else if (restore_req) begin
                        if (sp_q == {SP_W{1'b0}}) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= RESTORE;
                            cnt_q   <= {CNT_W{1'b0}};
                            sp_q    <= sp_q - SP_W'(1);
                        end
                    end
                end
                SAVE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= {CNT_W{1'b0}};
                        sp_q    <= sp_q + SP_W'(1);
                        state_q <= IDLE;
                    end
                end
                RESTORE: begin
                    regs_q[cnt_addr_s] <= stack_q[slot_s][cnt_q];
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= {CNT_W{1'b0}};
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            // Last assignment wins: io_in overrides any port or restore write.
            regs_q[IO_IN_A] <= io_in;
        end
    end

    // Frame memory is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == SAVE)) begin
            stack_q[slot_s][cnt_q] <= regs_q[cnt_addr_s];
        end
    end

    assign r1          = r1_q;
    assign r2          = r2_q;
    assign io_out      = io_out_q;
    assign busy        = (state_q != IDLE);
    assign stack_full  = (sp_q == SP_FULL);
    assign stack_empty = (sp_q == {SP_W{1'b0}});
    assign stack_err   = err_q;
endmodule

// File: tb/tb_regfile_frame_stack.sv
// Self-checking bench for regfile_frame_stack: directed scenarios with literal
// expectations plus randomized traffic against a frame-level behavioural model.
module tb_regfile_frame_stack;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  a1, a2;
    logic [15:0] w1, w2, io_in;
    logic        w1_en, w2_en, r1_en, r2_en, save_req, restore_req;
    logic [15:0] r1, r2, io_out;
    logic        busy, stack_full, stack_empty, stack_err;

    int tests = 0;
    int fails = 0;

    regfile_frame_stack dut (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .w1(w1), .w2(w2),
        .w1_en(w1_en), .w2_en(w2_en), .r1_en(r1_en), .r2_en(r2_en),
        .io_in(io_in), .save_req(save_req), .restore_req(restore_req),
        .r1(r1), .r2(r2), .io_out(io_out), .busy(busy),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: whole-frame copies at the accept edge, busy as a countdown.
    logic [15:0] regs_m  [64];
    logic [15:0] stack_m [8][15];
    logic [15:0] r1_m, r2_m, io_out_m, pre1, pre2;
    int          sp_m, busy_left, err_m;
    bit          save_pend, model_valid = 1'b0;

    function automatic logic [15:0] rdval(logic [5:0] a);
`ifdef REGFILE_WRITE_BYPASS_EN
        if (a == 6'd15) return io_in;
        if (w2_en && a2 == a) return w2;
        if (w1_en && a1 == a) return w1;
`endif
        return regs_m[a];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) regs_m[i] = 16'h0000;
            r1_m = 16'h0000; r2_m = 16'h0000; io_out_m = 16'h0000;
            sp_m = 0; busy_left = 0; err_m = 0; save_pend = 1'b0;
            model_valid = 1'b1;
        end else begin
            io_out_m = regs_m[16];
            if (busy_left == 0) begin
                pre1 = rdval(a1);
                pre2 = rdval(a2);
                if (r1_en) r1_m = pre1;
                if (r2_en) r2_m = pre2;
                if (w1_en) regs_m[a1] = w1;
                if (w2_en) regs_m[a2] = w2;
                if (save_req && restore_req) err_m = 1;
                else if (save_req) begin
                    if (sp_m == 8) err_m = 1;
                    else begin
                        for (int i = 0; i < 15; i++) stack_m[sp_m][i] = regs_m[i];
                        busy_left = 15; save_pend = 1'b1;
                    end
                end else if (restore_req) begin
                    if (sp_m == 0) err_m = 1;
                    else begin
                        sp_m = sp_m - 1;
                        for (int i = 0; i < 15; i++) regs_m[i] = stack_m[sp_m][i];
                        busy_left = 15; save_pend = 1'b0;
                    end
                end
            end else begin
                busy_left = busy_left - 1;
                if (busy_left == 0 && save_pend) begin
                    sp_m = sp_m + 1;
                    save_pend = 1'b0;
                end
            end
            regs_m[15] = io_in;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle, compare all outputs against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("r1", 32'(r1), 32'(r1_m));
            chk("r2", 32'(r2), 32'(r2_m));
            chk("io_out", 32'(io_out), 32'(io_out_m));
            chk("busy", 32'(busy), 32'(busy_left != 0));
            chk("stack_full", 32'(stack_full), 32'(sp_m == 8));
            chk("stack_empty", 32'(stack_empty), 32'(sp_m == 0));
            chk("stack_err", 32'(stack_err), 32'(err_m));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clr();
        w1_en = 1'b0; w2_en = 1'b0; r1_en = 1'b0; r2_en = 1'b0;
        save_req = 1'b0; restore_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; cyc(); reset = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            cyc();
            n++;
        end
        if (busy) chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wr1(input logic [5:0] a, input logic [15:0] d);
        clr(); a1 = a; w1 = d; w1_en = 1'b1; cyc(); clr();
    endtask

    task automatic do_save();
        clr(); save_req = 1'b1; cyc(); clr();
    endtask

    int n;

    initial begin
        reset = 1'b1; a1 = 6'd0; a2 = 6'd0; w1 = 16'h0000; w2 = 16'h0000; io_in = 16'h0000;
        clr();
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_r1", 32'(r1), 32'h0);
        chk("rst_io_out", 32'(io_out), 32'h0);
        chk("rst_empty", 32'(stack_empty), 32'h1);
        chk("rst_err", 32'(stack_err), 32'h0);

        // Write and same-edge read of address 3.
        a1 = 6'd3; w1 = 16'hBEEF; w1_en = 1'b1; r1_en = 1'b1; cyc(); clr();
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("same_edge_read", 32'(r1), 32'h0000BEEF);
`else
        chk("same_edge_read", 32'(r1), 32'h00000000);
`endif
        a1 = 6'd3; r1_en = 1'b1; cyc(); clr();
        chk("read_beef", 32'(r1), 32'h0000BEEF);

        // Port-2 priority on a colliding write.
        a1 = 6'd5; a2 = 6'd5; w1 = 16'h1111; w2 = 16'h2222; w1_en = 1'b1; w2_en = 1'b1; cyc(); clr();
        a2 = 6'd5; r2_en = 1'b1; cyc(); clr();
        chk("w2_wins", 32'(r2), 32'h00002222);

        // io_in lands in reg 15; reg 16 mirrored to io_out two edges after the write.
        io_in = 16'h00A5; cyc();
        a1 = 6'd15; r1_en = 1'b1; cyc(); clr();
        chk("io_in_reg", 32'(r1), 32'h000000A5);
        wr1(6'd16, 16'h0042);
        cyc();
        chk("io_out_mirror", 32'(io_out), 32'h00000042);

        // Save a frame; writes and reads during SAVE are dropped.
        for (int i = 0; i < 15; i++) wr1(6'(i), 16'(i + 1));
        do_save();
        chk("save_busy_start", 32'(busy), 32'h1);
        a1 = 6'd2; w1 = 16'hDEAD; w1_en = 1'b1; r1_en = 1'b1;
        wait_idle(n); clr();
        chk("save_busy_cycles", 32'(n), 32'd15);
        chk("r1_hold_busy", 32'(r1), 32'h000000A5);
        chk("sp1_not_empty", 32'(stack_empty), 32'h0);

        // Clobber and restore.
        for (int i = 0; i < 15; i++) wr1(6'(i), 16'h0000);
        restore_req = 1'b1; cyc(); clr();
        chk("restore_sp_dec", 32'(stack_empty), 32'h1);
        wait_idle(n);
        chk("restore_busy_cycles", 32'(n), 32'd15);
        for (int i = 0; i < 15; i++) begin
            a1 = 6'(i); r1_en = 1'b1; cyc(); clr();
            chk("restored_reg", 32'(r1), 32'(i + 1));
        end

        // Fill the stack, then overflow.
        for (int k = 0; k < 8; k++) begin
            do_save(); wait_idle(n);
        end
        chk("full_after_8", 32'(stack_full), 32'h1);
        do_save();
        chk("overflow_no_busy", 32'(busy), 32'h0);
        chk("overflow_err", 32'(stack_err), 32'h1);
        chk("overflow_still_full", 32'(stack_full), 32'h1);

        // Underflow after reset.
        do_reset();
        chk("err_cleared", 32'(stack_err), 32'h0);
        restore_req = 1'b1; cyc(); clr();
        chk("underflow_err", 32'(stack_err), 32'h1);
        chk("underflow_no_busy", 32'(busy), 32'h0);

        // Reset on busy cycle 7 aborts the save.
        do_reset();
        wr1(6'd4, 16'h0007);
        do_save();
        repeat (6) cyc();
        chk("busy_cycle7", 32'(busy), 32'h1);
        do_reset();
        chk("abort_idle", 32'(busy), 32'h0);
        chk("abort_sp0", 32'(stack_empty), 32'h1);
        a1 = 6'd4; r1_en = 1'b1; cyc(); clr();
        chk("abort_regs0", 32'(r1), 32'h0);

        // Simultaneous requests with sp == 2.
        do_save(); wait_idle(n);
        do_save(); wait_idle(n);
        save_req = 1'b1; restore_req = 1'b1; cyc(); clr();
        chk("conflict_no_busy", 32'(busy), 32'h0);
        chk("conflict_err", 32'(stack_err), 32'h1);
        restore_req = 1'b1; cyc(); clr(); wait_idle(n);
        chk("sp2_not_empty", 32'(stack_empty), 32'h0);
        restore_req = 1'b1; cyc(); clr(); wait_idle(n);
        chk("sp2_now_empty", 32'(stack_empty), 32'h1);

        // Randomized traffic checked every cycle by the compare process.
        for (int c = 0; c < 4000; c++) begin
            reset       = ($urandom_range(0, 299) == 0);
            a1          = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 20));
            a2          = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 20));
            w1          = 16'($urandom);
            w2          = 16'($urandom);
            io_in       = 16'($urandom);
            w1_en       = ($urandom_range(0, 1) == 1);
            w2_en       = ($urandom_range(0, 2) == 0);
            r1_en       = ($urandom_range(0, 1) == 1);
            r2_en       = ($urandom_range(0, 1) == 1);
            save_req    = ($urandom_range(0, 11) == 0);
            restore_req = ($urandom_range(0, 13) == 0);
            cyc();
        end
        reset = 1'b0; clr(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
